// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation frame scheduler: FSM state
// encoding and the width helpers used to size coordinate, index and sum ports.
package me_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD    = 3'd1;
  localparam logic [ST_W-1:0] ST_SEARCH  = 3'd2;
  localparam logic [ST_W-1:0] ST_RELEASE = 3'd3;
  localparam logic [ST_W-1:0] ST_EMIT    = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE    = 3'd5;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int mbi_width(input int cols, input int rows);
    return clog2_min1(cols * rows);
  endfunction

  // Wide enough to sum one full-scale SAD per macroblock without overflow.
  function automatic int frame_sad_width(input int sad_w, input int cols, input int rows);
    return sad_w + mbi_width(cols, rows) + 1;
  endfunction

endpackage

// File: rtl/me_sched_timeout.sv
// Loadable down-counter guarding the search phase; expired is raised while
// enabled with the count exhausted.
module me_sched_timeout #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/me_frame_scheduler.sv
// Frame-level scheduler: walks macroblocks in raster order, sequencing window
// load, motion search and result emission, and accumulates the frame SAD.
module me_frame_scheduler
  import me_pkg::*;
#(
  parameter int MB_COLS   = 4,
  parameter int MB_ROWS   = 3,
  parameter int CNT_WIDTH = 12,
  parameter int SAD_WIDTH = 16,
  parameter int TIMEOUT   = 65535,
  localparam int X_W   = clog2_min1(MB_COLS),
  localparam int Y_W   = clog2_min1(MB_ROWS),
  localparam int MBI_W = mbi_width(MB_COLS, MB_ROWS),
  localparam int FS_W  = frame_sad_width(SAD_WIDTH, MB_COLS, MB_ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 load_req,
  input  logic                 load_ack,
  output logic [X_W-1:0]       mb_x,
  output logic [Y_W-1:0]       mb_y,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  input  logic [CNT_WIDTH-1:0] me_min_mvec,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [MBI_W-1:0]     res_idx,
  output logic [CNT_WIDTH-1:0] res_mvec,
  output logic [SAD_WIDTH-1:0] res_sad,
  output logic [FS_W-1:0]      frame_sad,
  output logic [ST_W-1:0]      dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // Handshakes: load and search are req/ack; a request only counts as
  // acknowledged on a cycle where req and ack are both high, and the search
  // is 4-phase (req drops, then ack must drop). The result port is
  // valid/ready: res_* are held stable while res_valid is high and the
  // transfer happens on the rising edge where res_valid and res_ready are high.

  logic [ST_W-1:0]  state, state_nx;
  logic             have_res;
  logic             advance;
  logic             ack_hit;
  logic             last_mb;
  logic             tmo_expired, tmo_load, tmo_clr, tmo_en;
  logic [MBI_W-1:0] cur_idx;

  assign dbg_state = state;
  assign ack_hit   = (state == ST_SEARCH) && me_req && me_ack;
  assign last_mb   = (mb_x == X_W'(MB_COLS - 1)) && (mb_y == Y_W'(MB_ROWS - 1));
  assign cur_idx   = MBI_W'(mb_y) * MBI_W'(MB_COLS) + MBI_W'(mb_x);

  assign tmo_en   = (state == ST_SEARCH);
  assign tmo_load = (state != ST_SEARCH) && (state_nx == ST_SEARCH);
  assign tmo_clr  = (state_nx == ST_DONE);

  me_sched_timeout #(
    .W(TMO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .load     (tmo_load),
    .en       (tmo_en),
    .load_val (TMO_W'(TIMEOUT - 1)),
    .expired  (tmo_expired)
  );

  // advance marks the end of the current MB, emitted or timed out.
  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_req && load_ack) state_nx = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (ack_hit || tmo_expired) state_nx = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!me_ack) begin
          if (have_res) begin
            state_nx = ST_EMIT;
          end else begin
            advance  = 1'b1;
            state_nx = last_mb ? ST_DONE : ST_LOAD;
          end
        end
      end
      ST_EMIT: begin
        if (res_valid && res_ready) begin
          advance  = 1'b1;
          state_nx = last_mb ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // Abort wins over every other transition, including a completing emit.
    if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
      state_nx = ST_DONE;
      advance  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      load_req    <= 1'b0;
      me_req      <= 1'b0;
      res_valid   <= 1'b0;
      mb_x        <= '0;
      mb_y        <= '0;
      res_idx     <= '0;
      res_mvec    <= '0;
      res_sad     <= '0;
      frame_sad   <= '0;
      have_res    <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != ST_IDLE);
      done      <= (state_nx == ST_DONE);
      // Requests rise one cycle after the state is entered and drop with it.
      load_req  <= (state == ST_LOAD) && (state_nx == ST_LOAD);
      me_req    <= (state == ST_SEARCH) && (state_nx == ST_SEARCH);
      res_valid <= (state_nx == ST_EMIT);

      if ((state == ST_IDLE) && start) begin
        mb_x        <= '0;
        mb_y        <= '0;
        frame_sad   <= '0;
        err_timeout <= 1'b0;
        have_res    <= 1'b0;
      end

      if (ack_hit && (state_nx == ST_RELEASE)) begin
        res_sad  <= me_min_sad;
        res_mvec <= me_min_mvec;
        res_idx  <= cur_idx;
        have_res <= 1'b1;
      end

      if ((state == ST_SEARCH) && (state_nx == ST_RELEASE) && !ack_hit) begin
        err_timeout <= 1'b1;
      end

      if (advance) begin
        have_res <= 1'b0;
        if (state == ST_EMIT) begin
          frame_sad <= frame_sad + FS_W'(res_sad);
        end
        // Coordinates stay on the last MB so they never run past the frame.
        if (!last_mb) begin
          if (mb_x == X_W'(MB_COLS - 1)) begin
            mb_x <= '0;
            mb_y <= mb_y + 1'b1;
          end else begin
            mb_x <= mb_x + 1'b1;
          end
        end
      end

      if ((state_nx == ST_DONE) && (state != ST_DONE)) begin
        have_res <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Directed bench for me_frame_scheduler on a 2x2 frame with a short search
// timeout; a scoreboard of expected results is checked on every cycle.
`timescale 1ns/1ps
module tb_me_frame_scheduler;
  import me_pkg::*;

  localparam int COLS  = 2;
  localparam int ROWS  = 2;
  localparam int CW    = 12;
  localparam int SW    = 16;
  localparam int TMO   = 20;
  localparam int MBI_W = 2;
  localparam int FS_W  = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic load_ack = 1'b0;
  logic me_ack = 1'b0;
  logic res_ready = 1'b1;
  logic [SW-1:0] me_min_sad = '0;
  logic [CW-1:0] me_min_mvec = '0;
  logic busy, done, err_timeout, load_req, me_req, res_valid;
  logic [0:0] mb_x, mb_y;
  logic [MBI_W-1:0] res_idx;
  logic [CW-1:0] res_mvec;
  logic [SW-1:0] res_sad;
  logic [FS_W-1:0] frame_sad;
  logic [ST_W-1:0] dbg_state;

  me_frame_scheduler #(
    .MB_COLS(COLS), .MB_ROWS(ROWS), .CNT_WIDTH(CW), .SAD_WIDTH(SW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .load_req(load_req), .load_ack(load_ack), .mb_x(mb_x), .mb_y(mb_y),
    .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_mvec(res_mvec), .res_sad(res_sad), .frame_sad(frame_sad), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [29:0] exp_q[$];
  int sad_tab[4];
  int ack_delay = 5;
  int ack_hold = 0;
  int never_idx = -1;
  int stall_idx = -1;
  int stall_left = 0;
  int done_cnt = 0;
  int emit_cnt = 0;
  int stall_seen = 0;
  int tmo_len = 0;
  logic [FS_W-1:0] model_fsad = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver processes (change after the edge) ----------------
  always begin
    @(posedge clk); #1;
    load_ack = load_req && !rst;
  end

  int eng_cnt = 0;
  int hold_cnt = 0;
  always begin
    @(posedge clk); #1;
    if (rst) begin
      me_ack = 1'b0; eng_cnt = 0; hold_cnt = 0;
    end else if (me_ack) begin
      if (!me_req) begin
        if (hold_cnt >= ack_hold) begin
          me_ack = 1'b0; hold_cnt = 0;
        end else begin
          hold_cnt++;
        end
      end
    end else if (me_req) begin
      eng_cnt++;
      if ((eng_cnt >= ack_delay) && ((int'(mb_y) * COLS + int'(mb_x)) != never_idx)) begin
        me_ack      = 1'b1;
        me_min_sad  = 16'(sad_tab[int'(mb_y) * COLS + int'(mb_x)]);
        me_min_mvec = 12'(256 + int'(mb_y) * COLS + int'(mb_x));
        eng_cnt     = 0;
      end
    end else begin
      eng_cnt = 0;
    end
  end

  always begin
    @(posedge clk); #1;
    if (res_valid && (stall_left > 0) && (int'(res_idx) == stall_idx)) begin
      res_ready = 1'b0;
      stall_left--;
    end else begin
      res_ready = 1'b1;
    end
  end

  // ---------------- compare process (samples on falling edge) ----------------
  logic prev_stall = 1'b0;
  logic prev_me_req = 1'b0;
  logic prev_err = 1'b0;
  logic [29:0] prev_word = '0;
  int req_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0; prev_me_req = 1'b0; prev_err = 1'b0; req_run = 0;
    end else begin
      logic [29:0] w;
      if (done) done_cnt++;
      if (me_req && !prev_me_req) req_run = 1;
      else if (me_req) req_run++;
      if (err_timeout && !prev_err) tmo_len = (prev_me_req && !me_req) ? req_run : -1;
      if (busy) check("frame_sad", frame_sad, model_fsad);
      if (res_valid) check("ack_low_in_emit", me_ack, 0);
      if (res_valid && prev_stall) check("res_stable", {res_idx, res_mvec, res_sad}, prev_word);
      if (res_valid && res_ready && !abort) begin
        emit_cnt++;
        check("emit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("res_idx", res_idx, w[29:28]);
          check("res_mvec", res_mvec, w[27:16]);
          check("res_sad", res_sad, w[15:0]);
          model_fsad = model_fsad + FS_W'(w[15:0]);
        end
      end
      if (res_valid && !res_ready) stall_seen++;
      prev_stall  = res_valid && !res_ready;
      prev_word   = {res_idx, res_mvec, res_sad};
      prev_me_req = me_req;
      prev_err    = err_timeout;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic plan_frame(input int skip, input int upto);
    exp_q.delete();
    for (int i = 0; i < upto; i++)
      if (i != skip) exp_q.push_back({2'(i), 12'(256 + i), 16'(sad_tab[i])});
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    start = 1'b1; model_fsad = '0; done_cnt = 0; emit_cnt = 0; stall_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start_busy();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && (n < max)) begin @(negedge clk); n++; end
    check({name, "_finished"}, n < max, 1);
  endtask

  task automatic wait_search(input string name, input int x, input int y);
    int n = 0;
    while (!(me_req && (int'(mb_x) == x) && (int'(mb_y) == y)) && (n < 400)) begin
      @(negedge clk); n++;
    end
    check({name, "_reach_search"}, n < 400, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sad_tab = '{10, 20, 30, 40};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_load_req", load_req, 0);
    check("rst_me_req", me_req, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_frame_sad", frame_sad, 0);
    check("rst_mb_xy", {mb_y, mb_x}, 0);
    check("rst_res_idx", res_idx, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Basic frame: four MBs, SADs sum to 100.
    plan_frame(-1, 4);
    start_frame();
    wait_idle("t1", 600);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_frame_sad", frame_sad, 100);
    check("t1_emits", emit_cnt, 4);
    check("t1_queue_left", exp_q.size(), 0);
    check("t1_err", err_timeout, 0);

    // Backpressure on MB 1 for seven cycles.
    sad_tab = '{3, 7, 11, 15};
    stall_idx = 1; stall_left = 7;
    plan_frame(-1, 4);
    start_frame();
    wait_idle("t2", 600);
    check("t2_stall_cycles", stall_seen, 7);
    check("t2_emits", emit_cnt, 4);
    check("t2_frame_sad", frame_sad, 36);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_queue_left", exp_q.size(), 0);
    stall_idx = -1;

    // Engine never answers MB 2: timeout, MB 2 missing from the stream.
    sad_tab = '{10, 20, 30, 40};
    never_idx = 2;
    plan_frame(2, 4);
    start_frame();
    wait_idle("t3", 800);
    check("t3_err_timeout", err_timeout, 1);
    check("t3_me_req_len", tmo_len, TMO - 1);
    check("t3_emits", emit_cnt, 3);
    check("t3_frame_sad", frame_sad, 70);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_queue_left", exp_q.size(), 0);
    never_idx = -1;

    // Abort during search of MB 1.
    plan_frame(-1, 1);
    start_frame();
    @(negedge clk);
    check("t4_err_cleared", err_timeout, 0);
    wait_search("t4", 1, 0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t4_done_pulse", done, 1);
    check("t4_me_req_low", me_req, 0);
    check("t4_busy_in_done", busy, 1);
    check("t4_res_valid_low", res_valid, 0);
    @(negedge clk);
    check("t4_busy_after", busy, 0);
    check("t4_done_after", done, 0);
    repeat (20) @(negedge clk);
    check("t4_emits", emit_cnt, 1);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_frame_sad", frame_sad, 10);

    // Reset during LOAD of MB 2, then a fresh frame.
    plan_frame(-1, 4);
    start_frame();
    begin
      int n = 0;
      while (!(load_req && (mb_x == 1'b0) && (mb_y == 1'b1)) && (n < 400)) begin
        @(negedge clk); n++;
      end
      check("t5_reach_load", n < 400, 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_frame_sad", frame_sad, 0);
    check("t5_load_req", load_req, 0);
    check("t5_res_valid", res_valid, 0);
    repeat (5) @(negedge clk);
    check("t5_no_done", done_cnt, 0);
    plan_frame(-1, 4);
    start_frame();
    wait_idle("t5b", 600);
    check("t5b_emits", emit_cnt, 4);
    check("t5b_frame_sad", frame_sad, 100);
    check("t5b_done_cnt", done_cnt, 1);

    // Start while busy is ignored; ack held three extra cycles.
    ack_hold = 3;
    plan_frame(-1, 4);
    start_frame();
    wait_search("t6", 1, 0);
    pulse_start_busy();
    wait_idle("t6", 800);
    check("t6_emits", emit_cnt, 4);
    check("t6_frame_sad", frame_sad, 100);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_queue_left", exp_q.size(), 0);
    check("t6_state_idle", dbg_state, ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/me_frame_scheduler.md
ME_FRAME_SCHEDULER -- requirements
Module: me_frame_scheduler

Interface
REQ-001 Parameter MB_COLS, default 4: macroblocks per frame row, at least 1.
REQ-002 Parameter MB_ROWS, default 3: macroblock rows per frame, at least 1.
REQ-003 Parameter CNT_WIDTH, default 12: motion-vector/count width from the search engine.
REQ-004 Parameter SAD_WIDTH, default 16: SAD width from the search engine.
REQ-005 Parameter TIMEOUT, default 65535: maximum cycles allowed in SEARCH before aborting.
REQ-006 clk  in  1  sole clock; all logic rising-edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse; begins a frame when idle.
REQ-009 abort  in  1  level; terminates the frame at the next edge.
REQ-010 busy  out  1  high from the accepted start until DONE is left.
REQ-011 done  out  1  one-cycle pulse when a frame completes or aborts.
REQ-012 err_timeout  out  1  sticky; set on search timeout, cleared by start or rst.
REQ-013 load_req / load_ack  out / in  1 / 1  request/acknowledge for the window-memory loader of the current MB.
REQ-014 mb_x, mb_y  out  clog2(MB_COLS), clog2(MB_ROWS) (min 1)  current MB coordinates.
REQ-015 me_req / me_ack  out / in  1 / 1  search-engine handshake.
REQ-016 me_min_sad, me_min_mvec  in  SAD_WIDTH, CNT_WIDTH  engine results, valid while me_ack is high.
REQ-017 res_valid / res_ready  out / in  1 / 1  result stream handshake.
REQ-018 res_idx, res_mvec, res_sad  out  MBI_W=clog2(MB_COLS*MB_ROWS) (min 1), CNT_WIDTH, SAD_WIDTH  per-MB result.
REQ-019 frame_sad  out  SAD_WIDTH+MBI_W+1  accumulated SAD of all emitted MBs in the frame.

Function
REQ-020 FSM states: IDLE, LOAD, SEARCH, RELEASE, EMIT, DONE.
REQ-021 IDLE: start moves to LOAD, zeroes mb_x, mb_y, frame_sad and err_timeout; start is ignored in any other state.
REQ-022 LOAD: load_req is held high; load_ack high moves to SEARCH with load_req low on the following cycle.
REQ-023 SEARCH: me_req is held high; me_ack high latches me_min_sad and me_min_mvec and moves to RELEASE.
REQ-024 RELEASE: me_req is low; waits for me_ack low, then moves to EMIT, forming a 4-phase handshake.
REQ-025 EMIT: res_valid is high and res_* stay stable until res_ready; completion on the cycle where res_valid and res_ready are both high.
REQ-026 On EMIT completion, frame_sad += res_sad (full width, no overflow).
REQ-027 On EMIT completion, scan order is raster: mb_x increments; at MB_COLS-1 it wraps to 0 and mb_y increments.
REQ-028 On EMIT completion, the last MB (MB_COLS-1, MB_ROWS-1) goes to DONE; any other MB goes to LOAD.
REQ-029 res_idx equals mb_y*MB_COLS+mb_x of the emitted MB.
REQ-030 DONE lasts one cycle, pulses done, then goes to IDLE; frame_sad holds until the next start.
REQ-031 Timeout counter clears on SEARCH entry; when it reaches TIMEOUT with no me_ack, err_timeout is set and the FSM goes to RELEASE with no result emitted for that MB.
REQ-032 After a timeout, the next MB then proceeds per REQ-028; the missing res_idx is the error indication.
REQ-033 abort in any non-IDLE state forces DONE next cycle, drops load_req, me_req and res_valid, and discards the latched result.
REQ-034 abort outranks every other transition on the same edge, including an EMIT completion; that result is not counted in frame_sad.
REQ-035 A simultaneous me_ack and timeout edge counts as ack, not timeout.
REQ-036 With a single MB (MB_COLS=MB_ROWS=1), the flow is LOAD, SEARCH, RELEASE, EMIT, DONE.
REQ-037 All outputs are registered; load_req and me_req assert on the cycle after entering their state.

Reset
REQ-038 rst sets state=IDLE and clears busy, done, err_timeout, load_req, me_req, res_valid, mb_x, mb_y, res_*, frame_sad and the timeout counter.
REQ-039 rst mid-frame overrides abort and all other inputs; no done pulse is generated.

Structure
REQ-040 Shared package me_pkg holds the state enumeration and MBI_W/frame_sad width functions, reused with control_unit widths.
REQ-041 One sub-module me_sched_timeout (loadable down-counter, clear/enable, expiry flag) holds the timeout counter; the rest is one FSM module.

Verification
REQ-042 MB 2x2, engine acks after 5 cycles with sad=10,20,30,40 and res_ready=1: res_idx 0,1,2,3 emitted, frame_sad=100, one done pulse.
REQ-043 res_ready low for 7 cycles during EMIT of MB 1: res_* stable throughout, exactly one transfer, no MB skipped.
REQ-044 TIMEOUT=20, engine never acks MB 2: err_timeout rises at SEARCH cycle 20, idx 0,1,3 emitted, frame_sad excludes MB 2.
REQ-045 abort asserted in SEARCH of MB 1: done pulses next cycle, me_req low, busy low after DONE, no further res_valid.
REQ-046 rst pulsed during LOAD of MB 2, then start: frame restarts at idx 0, frame_sad=0, no done from the aborted frame.
REQ-047 start while busy and me_ack held high an extra 3 cycles: start ignored, RELEASE waits, single emit per MB.
